// File: rtl/timing_sequencer_pkg.sv
// Shared definitions for the T-state sequencer: state encodings, NUM_T range
// check and the TIMING_SEQ_IRQ_EN build switch (undefined by default: no interrupt entry).
package timing_sequencer_pkg;

    typedef enum logic [1:0] {
        SEQ_SYNC = 2'd0,
        SEQ_RUN  = 2'd1,
        SEQ_WAIT = 2'd2,
        SEQ_HALT = 2'd3
    } seq_state_e;

    localparam int NUM_T_MIN = 2;
    localparam int NUM_T_MAX = 16;

`ifdef TIMING_SEQ_IRQ_EN
    localparam bit SEQ_IRQ_EN = 1'b1;
`else
    localparam bit SEQ_IRQ_EN = 1'b0;
`endif

    function automatic bit num_t_legal(input int n);
        return (n >= NUM_T_MIN) && (n <= NUM_T_MAX);
    endfunction

endpackage

// File: rtl/decoder.sv
// Generic binary-to-one-hot decoder with enable; outputs beyond OUTS are dropped.
module decoder #(
    parameter int WIDTH = 3,
    parameter int OUTS  = 2**WIDTH
) (
    input  logic             en_i,
    input  logic [WIDTH-1:0] sel_i,
    output logic [OUTS-1:0]  dec_o
);

    always_comb begin
        dec_o = '0;
        for (int i = 0; i < OUTS; i++) begin
            dec_o[i] = en_i && (sel_i == WIDTH'(i));
        end
    end

endmodule

// File: rtl/timing_sequencer.sv
// Parametrised T-state sequencer: one-hot T vector plus binary time_cycle, with
// wait stretching, early clear, halt/resume and optional interrupt entry (TIMING_SEQ_IRQ_EN).
module timing_sequencer
    import timing_sequencer_pkg::*;
#(
    parameter int NUM_T = 8,
    parameter int CW    = $clog2(NUM_T)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             hlt,
    input  logic             hlt_req,
    input  logic             resume,
    input  logic             clr_timer,
    input  logic             wait_req,
    input  logic             irq,
    output logic [CW-1:0]    time_cycle,
    output logic [NUM_T-1:0] T,
    output logic             instr_start,
    output logic             irq_ack,
    output logic             irq_cycle,
    output logic             halted,
    output logic             seq_err
);

    generate
        if (!num_t_legal(NUM_T)) begin : g_bad_num_t
            $error("timing_sequencer: NUM_T out of range 2..16");
        end
    endgenerate

    seq_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
    logic          ack_q, ack_d;
    logic          icyc_q, icyc_d;
    logic          advance;
    logic          irq_ok;

    // No nesting: a request is only accepted outside an interrupt entry instruction.
    assign irq_ok = SEQ_IRQ_EN && irq && !icyc_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= SEQ_SYNC;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            ack_q   <= 1'b0;
            icyc_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            ack_q   <= ack_d;
            icyc_q  <= icyc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        ack_d   = 1'b0;
        icyc_d  = icyc_q;
        advance = 1'b0;
        case (state_q)
            SEQ_SYNC: begin
                cnt_d   = '0;
                state_d = hlt ? SEQ_HALT : SEQ_RUN;
            end
            SEQ_RUN: begin
                if (hlt || hlt_req) begin
                    state_d = SEQ_HALT;
                    cnt_d   = '0;
                end else if (wait_req) begin
                    state_d = SEQ_WAIT;
                end else if (clr_timer) begin
                    cnt_d = '0;
                    if (icyc_q) begin
                        icyc_d = 1'b0;
                    end else if (irq_ok) begin
                        ack_d  = 1'b1;
                        icyc_d = 1'b1;
                    end
                end else begin
                    advance = 1'b1;
                end
            end
            SEQ_WAIT: begin
                // The WAIT cycle in which wait_req drops is the repeat of the
                // stalled T-state, so leaving WAIT advances the count directly.
                if (hlt) begin
                    state_d = SEQ_HALT;
                    cnt_d   = '0;
                end else if (!wait_req) begin
                    state_d = SEQ_RUN;
                    advance = 1'b1;
                end
            end
            SEQ_HALT: begin
                cnt_d = '0;
                if (!hlt && (resume || irq_ok)) begin
                    state_d = SEQ_RUN;
                    if (irq_ok) begin
                        ack_d  = 1'b1;
                        icyc_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = SEQ_SYNC;
                cnt_d   = '0;
            end
        endcase
        if (advance) begin
            if (cnt_q == CW'(NUM_T - 1)) begin
                cnt_d = '0;
                err_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    decoder #(
        .WIDTH (CW),
        .OUTS  (NUM_T)
    ) u_tdec (
        .en_i  ((state_q == SEQ_RUN) || (state_q == SEQ_WAIT)),
        .sel_i (cnt_q),
        .dec_o (T)
    );

    assign time_cycle  = cnt_q;
    assign instr_start = (state_q == SEQ_RUN) && (cnt_q == '0);
    assign halted      = (state_q == SEQ_HALT);
    assign seq_err     = err_q;
    assign irq_ack     = ack_q;
    assign irq_cycle   = icyc_q;

endmodule

// File: tb/tb_timing_sequencer.sv
// Scoreboard bench for timing_sequencer (NUM_T=8): a cycle model pushes expected
// outputs as stimulus is driven; they are popped and compared one step later.
module tb_timing_sequencer;

    localparam int NT = 8;
`ifdef TIMING_SEQ_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif

    localparam int M_SYNC = 0, M_RUN = 1, M_WAIT = 2, M_HALT = 3;

    logic          clk = 1'b0;
    logic          reset, hlt, hlt_req, resume, clr_timer, wait_req, irq;
    logic [2:0]    time_cycle;
    logic [NT-1:0] T;
    logic          instr_start, irq_ack, irq_cycle, halted, seq_err;

    timing_sequencer #(.NUM_T(NT)) dut (
        .clk         (clk),
        .reset       (reset),
        .hlt         (hlt),
        .hlt_req     (hlt_req),
        .resume      (resume),
        .clr_timer   (clr_timer),
        .wait_req    (wait_req),
        .irq         (irq),
        .time_cycle  (time_cycle),
        .T           (T),
        .instr_start (instr_start),
        .irq_ack     (irq_ack),
        .irq_cycle   (irq_cycle),
        .halted      (halted),
        .seq_err     (seq_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] t;
        logic [2:0] tc;
        logic       is, hal, err, ack, icyc;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk = 0;
    int   n_err = 0;
    int   m_st, m_cnt;
    bit   m_err, m_ack, m_icyc;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, want);
        end
    endtask

    task automatic model_reset();
        m_st = M_SYNC; m_cnt = 0; m_err = 0; m_ack = 0; m_icyc = 0;
    endtask

    task automatic model_step(input bit h, hr, rs, cl, wr, iq);
        int  ns = m_st;
        int  nc = m_cnt;
        bit  go = 0;
        bit  take = IRQ_EN && iq && !m_icyc;
        m_ack = 0;
        if (m_st == M_SYNC) begin
            ns = h ? M_HALT : M_RUN;
        end else if (m_st == M_HALT) begin
            if (!h && (rs || take)) begin
                ns = M_RUN;
                if (take) begin m_ack = 1; m_icyc = 1; end
            end
        end else if (m_st == M_WAIT) begin
            if (h) begin ns = M_HALT; nc = 0; end
            else if (!wr) begin ns = M_RUN; go = 1; end
        end else begin
            if (h || hr) begin ns = M_HALT; nc = 0; end
            else if (wr) ns = M_WAIT;
            else if (cl) begin
                nc = 0;
                if (m_icyc) m_icyc = 0;
                else if (take) begin m_ack = 1; m_icyc = 1; end
            end else go = 1;
        end
        if (go) begin
            nc = (m_cnt + 1) % NT;
            if (m_cnt == NT - 1) m_err = 1;
        end
        m_st = ns;
        m_cnt = nc;
    endtask

    function automatic exp_t model_out();
        exp_t e;
        bit   run = (m_st == M_RUN) || (m_st == M_WAIT);
        e.t    = run ? (8'h01 << m_cnt) : 8'h00;
        e.tc   = run ? 3'(m_cnt) : 3'd0;
        e.is   = (m_st == M_RUN) && (m_cnt == 0);
        e.hal  = (m_st == M_HALT);
        e.err  = m_err;
        e.ack  = m_ack;
        e.icyc = m_icyc;
        return e;
    endfunction

    task automatic step(input bit h, hr, rs, cl, wr, iq);
        exp_t e;
        hlt = h; hlt_req = hr; resume = rs; clr_timer = cl; wait_req = wr; irq = iq;
        model_step(h, hr, rs, cl, wr, iq);
        exp_q.push_back(model_out());
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            chk("sb_empty", 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            chk("sb_T", 32'(T), 32'(e.t));
            chk("sb_time_cycle", 32'(time_cycle), 32'(e.tc));
            chk("sb_instr_start", 32'(instr_start), 32'(e.is));
            chk("sb_halted", 32'(halted), 32'(e.hal));
            chk("sb_seq_err", 32'(seq_err), 32'(e.err));
            chk("sb_irq_ack", 32'(irq_ack), 32'(e.ack));
            chk("sb_irq_cycle", 32'(irq_cycle), 32'(e.icyc));
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        reset = 1'b0; hlt = 0; hlt_req = 0; resume = 0; clr_timer = 0; wait_req = 0; irq = 0;
        #2;
        chk("rst_T", 32'(T), 32'd0);
        chk("rst_tc", 32'(time_cycle), 32'd0);
        chk("rst_flags", {27'd0, instr_start, irq_ack, irq_cycle, halted, seq_err}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        #1;
        chk("sync_T", 32'(T), 32'd0);

        // Reset release walk: T0, T1, T2
        idle(1);
        chk("walk_T0", 32'(T), 32'h01);
        idle(2);
        chk("walk_T2", 32'(T), 32'h04);

        // Early clear at T2
        step(0, 0, 0, 1, 0, 0);
        chk("clr_T", 32'(T), 32'h01);
        chk("clr_start", 32'(instr_start), 32'd1);
        chk("clr_err", 32'(seq_err), 32'd0);

        // Three wait cycles at T1
        idle(1);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0, 1, 0);
            chk("wait_hold_T", 32'(T), 32'h02);
        end
        idle(1);
        chk("wait_exit_T", 32'(T), 32'h04);

        // Wrap without clr_timer: now at T2, five more to T7, then wrap
        idle(5);
        chk("pre_wrap_err", 32'(seq_err), 32'd0);
        idle(1);
        chk("wrap_T", 32'(T), 32'h01);
        chk("wrap_err", 32'(seq_err), 32'd1);
        step(0, 0, 0, 1, 0, 0);
        idle(3);
        chk("err_sticky", 32'(seq_err), 32'd1);

        // Halt via hlt_req at T1; resume blocked while hlt is high
        step(0, 0, 0, 1, 0, 0);
        idle(1);
        step(0, 1, 0, 0, 0, 0);
        chk("halt_halted", 32'(halted), 32'd1);
        chk("halt_T", 32'(T), 32'd0);
        step(1, 0, 1, 0, 0, 0);
        chk("halt_blocked", 32'(halted), 32'd1);
        idle(1);
        step(0, 0, 1, 0, 0, 0);
        chk("resume_T", 32'(T), 32'h01);
        chk("resume_halted", 32'(halted), 32'd0);

        // Interrupt at a clr_timer edge
        idle(2);
        step(0, 0, 0, 1, 0, 1);
        chk("irq_ack", 32'(irq_ack), 32'(IRQ_EN));
        step(0, 0, 0, 0, 0, 1);
        chk("irq_ack_pulse", 32'(irq_ack), 32'd0);
        chk("irq_cycle_hold", 32'(irq_cycle), 32'(IRQ_EN));
        step(0, 0, 0, 1, 0, 0);
        chk("irq_cycle_clr", 32'(irq_cycle), 32'd0);

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(99) < 3, $urandom_range(99) < 3, $urandom_range(99) < 15,
                 $urandom_range(99) < 20, $urandom_range(99) < 15, $urandom_range(99) < 10);
        end

        // Asynchronous reset mid-cycle
        step(0, 0, 1, 0, 0, 0);
        idle(2);
        #3;
        reset = 1'b0;
        #1;
        chk("arst_T", 32'(T), 32'd0);
        chk("arst_tc", 32'(time_cycle), 32'd0);
        chk("arst_flags", {27'd0, instr_start, irq_ack, irq_cycle, halted, seq_err}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        idle(3);
        chk("post_rst_T", 32'(T), 32'h04);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
